// File: rtl/progress_watchdog.sv
// progress_watchdog
//   Run-progress monitor that sits beside the processor top. It watches the
//   fetch PC, the retire ports and the flush bus, and reports two terminal
//   conditions through a sticky status FSM:
//     DONE     - PC held constant for STALL_CYCLES cycles (bootstrap self-loop)
//     DEADLOCK - no retirement on any channel for DEADLOCK_CYCLES cycles
//   Saturating statistics count RUN cycles, retirements and flushes.
//
//   Optional feature (macro FLUSH_STORM_EN): a sliding STORM_WINDOW-cycle
//   flush history raises a sticky flush_storm flag once STORM_LIMIT or more
//   flushes fall inside the window. Without the macro flush_storm is 0.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous reset, active-high
//   enable       in   arms monitoring; low holds statistics, FSM to IDLE
//   current_pc   in   fetch PC, sampled every cycle
//   commit_valid in   one bit per retire channel
//   flush_valid  in   pipeline flush this cycle
//   state_o      out  00 IDLE, 01 RUN, 10 DONE, 11 DEADLOCK
//   sim_finished out  high while in DONE
//   deadlock     out  high while in DEADLOCK
//   cycle_cnt    out  cycles spent counting (RUN, including the arming cycle)
//   commit_cnt   out  total retirements
//   flush_cnt    out  total flushes
//   flush_storm  out  sticky flush-storm flag
module progress_watchdog #(
    parameter int PC_W            = 32,
    parameter int N_COMMIT        = 2,
    parameter int STALL_CYCLES    = 500,
    parameter int DEADLOCK_CYCLES = 4096,
    parameter int CNT_W           = 32,
    parameter int STORM_WINDOW    = 64,
    parameter int STORM_LIMIT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PC_W-1:0]     current_pc,
    input  logic [N_COMMIT-1:0] commit_valid,
    input  logic                flush_valid,
    output logic [1:0]          state_o,
    output logic                sim_finished,
    output logic                deadlock,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    commit_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
    output logic                flush_storm
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        DONE     = 2'b10,
        DEADLOCK = 2'b11
    } state_t;

    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int IDLE_W  = $clog2(DEADLOCK_CYCLES + 1);
    localparam int POP_W   = $clog2(N_COMMIT + 1);

    // Elaboration-time parameter sanity.
    if (N_COMMIT < 1 || N_COMMIT > 4) begin : g_bad_commit
        $error("progress_watchdog: N_COMMIT must be 1..4");
    end
    if (STORM_WINDOW < 2 || STORM_LIMIT < 1 || STORM_LIMIT > STORM_WINDOW) begin : g_bad_storm
        $error("progress_watchdog: STORM_LIMIT must be 1..STORM_WINDOW, STORM_WINDOW >= 2");
    end

    state_t             state;
    logic [PC_W-1:0]    old_pc;
    logic [STALL_W-1:0] stall_cnt;
    logic [IDLE_W-1:0]  idle_cnt;

    logic [POP_W-1:0]   commit_pop;
    logic               pc_same;
    logic               no_commit;
    logic               stall_hit;
    logic               idle_hit;
    logic               count_en;
    logic [STALL_W-1:0] stall_inc;
    logic [IDLE_W-1:0]  idle_inc;

    // Saturating add: statistics stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        commit_pop = '0;
        for (int i = 0; i < N_COMMIT; i++) begin
            commit_pop = commit_pop + POP_W'(commit_valid[i]);
        end
    end

    // Statistics count in the arming cycle as well as in every RUN cycle.
    assign count_en  = enable && (state == IDLE || state == RUN);
    assign pc_same   = (current_pc == old_pc);
    assign no_commit = (commit_valid == '0);

    // Threshold test uses the value before the increment, so the N-th
    // qualifying cycle is the one that fires.
    assign stall_hit = pc_same   && (stall_cnt == STALL_W'(STALL_CYCLES - 1));
    assign idle_hit  = no_commit && (idle_cnt  == IDLE_W'(DEADLOCK_CYCLES - 1));

    assign stall_inc = (stall_cnt == STALL_W'(STALL_CYCLES))  ? stall_cnt : stall_cnt + STALL_W'(1);
    assign idle_inc  = (idle_cnt  == IDLE_W'(DEADLOCK_CYCLES)) ? idle_cnt  : idle_cnt  + IDLE_W'(1);

    assign state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            old_pc       <= '0;
            stall_cnt    <= '0;
            idle_cnt     <= '0;
            cycle_cnt    <= '0;
            commit_cnt   <= '0;
            flush_cnt    <= '0;
            sim_finished <= 1'b0;
            deadlock     <= 1'b0;
        end else begin
            if (count_en) begin
                cycle_cnt  <= sat_add(cycle_cnt, CNT_W'(1));
                commit_cnt <= sat_add(commit_cnt, CNT_W'(commit_pop));
                flush_cnt  <= sat_add(flush_cnt, CNT_W'(flush_valid));
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= RUN;
                        old_pc    <= current_pc;
                        stall_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state     <= IDLE;
                        stall_cnt <= '0;
                        idle_cnt  <= '0;
                    end else begin
                        // Only a PC change restarts the stall count; flushes do not.
                        if (pc_same) begin
                            stall_cnt <= stall_inc;
                        end else begin
                            stall_cnt <= '0;
                            old_pc    <= current_pc;
                        end
                        idle_cnt <= no_commit ? idle_inc : '0;

                        // A silent self-loop is a clean end, so DONE outranks DEADLOCK.
                        if (stall_hit) begin
                            state        <= DONE;
                            sim_finished <= 1'b1;
                        end else if (idle_hit) begin
                            state    <= DEADLOCK;
                            deadlock <= 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE and DEADLOCK hold until rst.
                end
            endcase
        end
    end

`ifdef FLUSH_STORM_EN
    localparam int SW_W = $clog2(STORM_WINDOW + 1);

    logic [STORM_WINDOW-1:0] storm_win;
    logic [SW_W-1:0]         storm_ones;
    logic [SW_W-1:0]         storm_ones_next;

    // Running population count of the window: new bit in, oldest bit out.
    assign storm_ones_next = storm_ones + SW_W'(flush_valid)
                           - SW_W'(storm_win[STORM_WINDOW-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            storm_win   <= '0;
            storm_ones  <= '0;
            flush_storm <= 1'b0;
        end else if (count_en) begin
            storm_win  <= {storm_win[STORM_WINDOW-2:0], flush_valid};
            storm_ones <= storm_ones_next;
            if (storm_ones_next >= SW_W'(STORM_LIMIT)) begin
                flush_storm <= 1'b1;
            end
        end
    end
`else
    assign flush_storm = 1'b0;
`endif

endmodule

// File: tb/tb_progress_watchdog.sv
// tb_progress_watchdog
//   Drives two progress_watchdog instances from the same inputs:
//     dut_a - default thresholds (500 / 4096), 32-bit statistics
//     dut_b - 8 / 8 thresholds, 8-bit statistics (saturation, tie-break)
//   A behavioural model tracks run lengths, totals and the flush window
//   per instance and every output is compared each cycle.
module tb_progress_watchdog;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] current_pc;
    logic [1:0]  commit_valid;
    logic        flush_valid;

    logic [1:0]  st_a, st_b;
    logic        sf_a, sf_b, dl_a, dl_b, storm_a, storm_b;
    logic [31:0] cyc_a, com_a, fl_a;
    logic [7:0]  cyc_b, com_b, fl_b;

    always #5 clk = ~clk;

    progress_watchdog #(
        .PC_W(32), .N_COMMIT(2), .STALL_CYCLES(500), .DEADLOCK_CYCLES(4096),
        .CNT_W(32), .STORM_WINDOW(64), .STORM_LIMIT(16)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .current_pc(current_pc),
        .commit_valid(commit_valid), .flush_valid(flush_valid),
        .state_o(st_a), .sim_finished(sf_a), .deadlock(dl_a),
        .cycle_cnt(cyc_a), .commit_cnt(com_a), .flush_cnt(fl_a),
        .flush_storm(storm_a)
    );

    progress_watchdog #(
        .PC_W(32), .N_COMMIT(2), .STALL_CYCLES(8), .DEADLOCK_CYCLES(8),
        .CNT_W(8), .STORM_WINDOW(64), .STORM_LIMIT(16)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .current_pc(current_pc),
        .commit_valid(commit_valid), .flush_valid(flush_valid),
        .state_o(st_b), .sim_finished(sf_b), .deadlock(dl_b),
        .cycle_cnt(cyc_b), .commit_cnt(com_b), .flush_cnt(fl_b),
        .flush_storm(storm_b)
    );

`ifdef FLUSH_STORM_EN
    localparam bit STORM_ON = 1'b1;
`else
    localparam bit STORM_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: 0 IDLE, 1 RUN, 2 DONE, 3 DEADLOCK
    int              m_st[2];
    longint unsigned m_cyc[2], m_com[2], m_fl[2];
    longint unsigned m_max[2] = '{64'hFFFF_FFFF, 64'hFF};
    int              s_th[2]  = '{500, 8};
    int              d_th[2]  = '{4096, 8};
    logic [31:0]     m_old[2];
    int              m_eq[2];   // consecutive cycles with PC equal to the held PC
    int              m_dry[2];  // consecutive cycles with no retirement
    bit              m_storm[2];
    bit              hist0[$];
    bit              hist1[$];

    function automatic longint unsigned sat(input longint unsigned v, input longint unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int window_push(input int k, input bit f);
        int s = 0;
        if (k == 0) begin
            hist0.push_back(f);
            if (hist0.size() > 64) void'(hist0.pop_front());
            foreach (hist0[i]) s += hist0[i];
        end else begin
            hist1.push_back(f);
            if (hist1.size() > 64) void'(hist1.pop_front());
            foreach (hist1[i]) s += hist1[i];
        end
        return s;
    endfunction

    task automatic model_step(input int k);
        int  pop;
        bit  same;
        pop = int'(commit_valid[0]) + int'(commit_valid[1]);
        if (rst) begin
            m_st[k] = 0; m_cyc[k] = 0; m_com[k] = 0; m_fl[k] = 0;
            m_old[k] = 0; m_eq[k] = 0; m_dry[k] = 0; m_storm[k] = 0;
            if (k == 0) hist0.delete(); else hist1.delete();
        end else if (enable && (m_st[k] == 0 || m_st[k] == 1)) begin
            m_cyc[k] = sat(m_cyc[k] + 1, m_max[k]);
            m_com[k] = sat(m_com[k] + longint'(pop), m_max[k]);
            m_fl[k]  = sat(m_fl[k] + longint'(flush_valid), m_max[k]);
            if (window_push(k, flush_valid) >= 16) m_storm[k] = 1;
            if (m_st[k] == 0) begin
                m_st[k] = 1; m_old[k] = current_pc; m_eq[k] = 0; m_dry[k] = 0;
            end else begin
                same = (current_pc == m_old[k]);
                m_eq[k]  = same ? m_eq[k] + 1 : 0;
                if (!same) m_old[k] = current_pc;
                m_dry[k] = (pop == 0) ? m_dry[k] + 1 : 0;
                if (m_eq[k] == s_th[k])       m_st[k] = 2;
                else if (m_dry[k] == d_th[k]) m_st[k] = 3;
            end
        end else if (!enable && m_st[k] == 1) begin
            m_st[k] = 0; m_eq[k] = 0; m_dry[k] = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("a.state",  st_a,  m_st[0]);
        check_eq("a.sim_fin", sf_a, m_st[0] == 2);
        check_eq("a.deadlock", dl_a, m_st[0] == 3);
        check_eq("a.cycle_cnt", cyc_a, m_cyc[0]);
        check_eq("a.commit_cnt", com_a, m_com[0]);
        check_eq("a.flush_cnt", fl_a, m_fl[0]);
        check_eq("a.storm", storm_a, STORM_ON & m_storm[0]);
        check_eq("b.state",  st_b,  m_st[1]);
        check_eq("b.sim_fin", sf_b, m_st[1] == 2);
        check_eq("b.deadlock", dl_b, m_st[1] == 3);
        check_eq("b.cycle_cnt", cyc_b, m_cyc[1]);
        check_eq("b.commit_cnt", com_b, m_com[1]);
        check_eq("b.flush_cnt", fl_b, m_fl[1]);
        check_eq("b.storm", storm_b, STORM_ON & m_storm[1]);
    endtask

    // One clock: drive after the falling edge, update model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic r, input logic e, input logic [31:0] pc,
                        input logic [1:0] cv, input logic fv);
        rst = r; enable = e; current_pc = pc; commit_valid = cv; flush_valid = fv;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    logic [31:0] pc;

    initial begin
        pc = 32'h0000_1000;

        // Reset and arm
        repeat (3) step(1'b1, 1'b0, pc, 2'b00, 1'b0);
        check_eq("rst.state", st_a, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, pc, 2'b11, 1'b0);
            pc += 4;
        end
        check_eq("arm.state", st_a, 1);
        check_eq("arm.commit_cnt", com_a, 20);
        check_eq("arm.cycle_cnt", cyc_a, 10);
        check_eq("arm.sim_fin", sf_a, 0);

        // Random traffic with occasional enable drops and PC holds
        for (int i = 0; i < 400; i++) begin
            logic e;
            logic fv;
            e  = ($urandom_range(0, 19) != 0);
            fv = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) != 0) pc += 4 * $urandom_range(1, 4);
            step(1'b0, e, pc, 2'($urandom), fv);
        end

        // End of program on dut_a: first cycle at 0x100 is a PC change
        pc = 32'h0000_0100;
        for (int i = 0; i <= 500; i++) begin
            step(1'b0, 1'b1, pc, 2'b01, 1'b0);
            if (i == 499) check_eq("eop.before", sf_a, 0);
        end
        check_eq("eop.sim_fin", sf_a, 1);
        check_eq("eop.state", st_a, 2);
        for (int i = 0; i < 20; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b11, 1'b1);
        end
        check_eq("eop.sticky", sf_a, 1);

        // Reset from DONE, then re-arm
        step(1'b1, 1'b1, pc, 2'b11, 1'b1);
        check_eq("mid.state", st_a, 0);
        check_eq("mid.cycle_cnt", cyc_a, 0);
        check_eq("mid.commit_cnt", com_a, 0);
        check_eq("mid.flush_cnt", fl_a, 0);
        for (int i = 0; i < 5; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b11, 1'b0);
        end
        check_eq("rearm.cycle_cnt", cyc_a, 5);
        check_eq("rearm.commit_cnt", com_a, 10);

        // Near-miss deadlock: 4095 silent cycles, then a single commit
        for (int i = 0; i < 4095; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b00, 1'b0);
        end
        pc += 4;
        step(1'b0, 1'b1, pc, 2'b10, 1'b0);
        for (int i = 0; i < 200; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b00, 1'b0);
        end
        check_eq("nearmiss.state", st_a, 1);
        check_eq("nearmiss.deadlock", dl_a, 0);

        // Deadlock: arm, then 4096 silent cycles with a moving PC
        step(1'b1, 1'b0, pc, 2'b00, 1'b0);
        step(1'b0, 1'b1, pc, 2'b00, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b00, 1'b0);
            if (i == 4094) check_eq("dl.before", dl_a, 0);
        end
        check_eq("dl.deadlock", dl_a, 1);
        check_eq("dl.state", st_a, 3);

        // Simultaneous stall and idle on dut_b: DONE wins
        step(1'b1, 1'b0, pc, 2'b00, 1'b0);
        step(1'b0, 1'b1, pc, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, pc, 2'b00, 1'b0);
            if (i == 6) check_eq("sim.before", st_b, 1);
        end
        check_eq("sim.state", st_b, 2);
        check_eq("sim.deadlock", dl_b, 0);

        // Flush storm: 15 flushes spread over 64 cycles stays quiet
        step(1'b1, 1'b0, pc, 2'b00, 1'b0);
        step(1'b0, 1'b1, pc, 2'b11, 1'b0);
        for (int i = 0; i < 128; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b11, (i % 4 == 0) && (i < 60));
        end
        check_eq("storm15.flag", storm_a, 0);
        check_eq("storm15.flush_cnt", fl_a, 15);

        // 16 flushes within 40 cycles
        step(1'b1, 1'b0, pc, 2'b00, 1'b0);
        step(1'b0, 1'b1, pc, 2'b11, 1'b0);
        for (int i = 0; i < 40; i++) begin
            pc += 4;
            step(1'b0, 1'b1, pc, 2'b01, (i % 2 == 0) && (i < 32));
        end
        check_eq("storm16.flag", storm_a, STORM_ON);
        check_eq("storm16.flush_cnt", fl_a, 16);
        check_eq("storm16.state", st_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
